// File: rtl/count_monitor.sv
// Observer for an up/down counter output: running min/max, modular step, wrap counts
// and hysteresis threshold alarms. Define COUNT_MONITOR_SAT_EN for saturating wrap counters.
module count_monitor #(
  parameter int W    = 8,
  parameter int HOLD = 2,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  q_in,
  input  logic          sample,
  input  logic          clr,
  input  logic [W-1:0]  hi_thr,
  input  logic [W-1:0]  lo_thr,
  output logic [W-1:0]  q_min,
  output logic [W-1:0]  q_max,
  output logic [W-1:0]  delta,
  output logic [CW-1:0] wrap_up_cnt,
  output logic [CW-1:0] wrap_dn_cnt,
  output logic          alarm_hi,
  output logic          alarm_lo
);

  localparam int SW = $clog2(HOLD + 1);
  localparam logic [SW-1:0] HOLD_V = SW'(HOLD);
  localparam logic [W-1:0]  ONES   = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, TRACK, ALARM_HI, ALARM_LO} state_t;

  state_t         state;
  logic [W-1:0]   prev;
  logic           prev_valid;
  logic [SW-1:0]  streak;
  logic           streak_hi;

  logic           q_hi;
  logic           q_lo;
  logic           wrap_up_hit;
  logic           wrap_dn_hit;
  logic [SW-1:0]  run_len;

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] cnt);
`ifdef COUNT_MONITOR_SAT_EN
    return (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
`else
    return cnt + 1'b1;
`endif
  endfunction

  always_comb begin
    q_hi        = q_in > hi_thr;
    q_lo        = !q_hi && (q_in < lo_thr);
    wrap_up_hit = prev_valid && (prev == ONES) && (q_in == '0);
    wrap_dn_hit = prev_valid && (prev == '0) && (q_in == ONES);
    run_len     = '0;
    // A streak continues only while the qualifying direction is unchanged.
    if (q_hi || q_lo) begin
      if (streak != '0 && streak_hi == q_hi)
        run_len = (streak >= HOLD_V) ? streak : streak + 1'b1;
      else
        run_len = SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_min       <= ONES;
      q_max       <= '0;
      delta       <= '0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
      alarm_hi    <= 1'b0;
      alarm_lo    <= 1'b0;
      state       <= IDLE;
      streak      <= '0;
      streak_hi   <= 1'b0;
      prev        <= '0;
      prev_valid  <= 1'b0;
    end else if (clr) begin
      q_min       <= ONES;
      q_max       <= '0;
      delta       <= '0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
      alarm_hi    <= 1'b0;
      alarm_lo    <= 1'b0;
      state       <= IDLE;
      streak      <= '0;
      streak_hi   <= 1'b0;
      prev        <= '0;
      prev_valid  <= 1'b0;
    end else if (sample) begin
      if (q_in < q_min) q_min <= q_in;
      if (q_in > q_max) q_max <= q_in;
      prev       <= q_in;
      prev_valid <= 1'b1;
      delta      <= prev_valid ? q_in - prev : '0;
      if (wrap_up_hit) wrap_up_cnt <= bump(wrap_up_cnt);
      if (wrap_dn_hit) wrap_dn_cnt <= bump(wrap_dn_cnt);

      case (state)
        IDLE: begin
          state     <= TRACK;
          streak    <= run_len;
          streak_hi <= q_hi;
        end
        TRACK: begin
          if (run_len >= HOLD_V) begin
            state    <= q_hi ? ALARM_HI : ALARM_LO;
            alarm_hi <= q_hi;
            alarm_lo <= !q_hi;
            streak   <= '0;
          end else begin
            streak    <= run_len;
            streak_hi <= q_hi;
          end
        end
        ALARM_HI: begin
          // The exit sample seeds a lo streak; no direct jump to ALARM_LO.
          if (!q_hi) begin
            state     <= TRACK;
            alarm_hi  <= 1'b0;
            streak    <= q_lo ? SW'(1) : '0;
            streak_hi <= 1'b0;
          end else begin
            streak <= '0;
          end
        end
        ALARM_LO: begin
          if (q_in >= lo_thr) begin
            state     <= TRACK;
            alarm_lo  <= 1'b0;
            streak    <= q_hi ? SW'(1) : '0;
            streak_hi <= 1'b1;
          end else begin
            streak <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor at W=8, HOLD=2, CW=4.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] q_in = '0;
  logic       sample = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] hi_thr = 8'hC8;
  logic [7:0] lo_thr = 8'h10;
  logic [7:0] q_min, q_max, delta;
  logic [3:0] wrap_up_cnt, wrap_dn_cnt;
  logic       alarm_hi, alarm_lo;

  int errors = 0;
  int checks = 0;

  count_monitor #(.W(8), .HOLD(2), .CW(4)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .sample(sample), .clr(clr),
    .hi_thr(hi_thr), .lo_thr(lo_thr), .q_min(q_min), .q_max(q_max),
    .delta(delta), .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt),
    .alarm_hi(alarm_hi), .alarm_lo(alarm_lo)
  );

  always #5 clk = ~clk;

  task automatic samp(input logic [7:0] v);
    q_in = v;
    sample = 1'b1;
    @(posedge clk);
    #1;
    sample = 1'b0;
    $display("sample q_in=%h -> min=%h max=%h delta=%h up=%0d dn=%0d ahi=%b alo=%b",
             v, q_min, q_max, delta, wrap_up_cnt, wrap_dn_cnt, alarm_hi, alarm_lo);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    $display("clr");
  endtask

  task automatic test_reset();
    samp(8'h40); samp(8'h80); samp(8'hFF); samp(8'h00);
    #2 rst = 1'b1;
    #1;
    checks++; if (q_min !== 8'hFF) begin errors++; $display("FAIL rst_q_min got %h want FF", q_min); end
    checks++; if (q_max !== 8'h00) begin errors++; $display("FAIL rst_q_max got %h want 00", q_max); end
    checks++; if (delta !== 8'h00) begin errors++; $display("FAIL rst_delta got %h want 00", delta); end
    checks++; if (wrap_up_cnt !== 4'd0 || wrap_dn_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_wraps got %0d/%0d want 0/0", wrap_up_cnt, wrap_dn_cnt); end
    checks++; if (alarm_hi !== 1'b0 || alarm_lo !== 1'b0) begin
      errors++; $display("FAIL rst_alarms got %b%b want 00", alarm_hi, alarm_lo); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_minmax();
    do_clr();
    samp(8'h05);
    checks++; if (delta !== 8'h00) begin errors++; $display("FAIL first_delta got %h want 00", delta); end
    samp(8'h07);
    checks++; if (delta !== 8'h02) begin errors++; $display("FAIL delta_up got %h want 02", delta); end
    samp(8'h03);
    checks++; if (q_min !== 8'h03) begin errors++; $display("FAIL minmax_q_min got %h want 03", q_min); end
    checks++; if (q_max !== 8'h07) begin errors++; $display("FAIL minmax_q_max got %h want 07", q_max); end
    checks++; if (delta !== 8'hFC) begin errors++; $display("FAIL minmax_delta got %h want FC", delta); end
  endtask

  task automatic test_hold();
    q_in = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q_min !== 8'h03 || q_max !== 8'h07 || delta !== 8'hFC) begin
      errors++; $display("FAIL hold got min=%h max=%h delta=%h want 03 07 FC", q_min, q_max, delta); end
  endtask

  task automatic test_wrap();
    samp(8'hFE); samp(8'hFF);
    checks++; if (wrap_up_cnt !== 4'd0) begin errors++; $display("FAIL no_wrap got %0d want 0", wrap_up_cnt); end
    samp(8'h00);
    checks++; if (wrap_up_cnt !== 4'd1) begin errors++; $display("FAIL wrap_up got %0d want 1", wrap_up_cnt); end
    checks++; if (delta !== 8'h01) begin errors++; $display("FAIL wrap_up_delta got %h want 01", delta); end
    samp(8'h00);
    checks++; if (wrap_up_cnt !== 4'd1 || wrap_dn_cnt !== 4'd0) begin
      errors++; $display("FAIL repeat_no_wrap got %0d/%0d want 1/0", wrap_up_cnt, wrap_dn_cnt); end
    samp(8'hFF);
    checks++; if (wrap_dn_cnt !== 4'd1) begin errors++; $display("FAIL wrap_dn got %0d want 1", wrap_dn_cnt); end
    checks++; if (delta !== 8'hFF) begin errors++; $display("FAIL wrap_dn_delta got %h want FF", delta); end
  endtask

  task automatic test_alarm();
    do_clr();
    hi_thr = 8'hC8; lo_thr = 8'h10;
    samp(8'hC9); samp(8'h50); samp(8'hC9);
    checks++; if (alarm_hi !== 1'b0) begin errors++; $display("FAIL hi_early got %b want 0", alarm_hi); end
    samp(8'hCA);
    checks++; if (alarm_hi !== 1'b1) begin errors++; $display("FAIL hi_enter got %b want 1", alarm_hi); end
    samp(8'hC8);
    checks++; if (alarm_hi !== 1'b0) begin errors++; $display("FAIL hi_exit got %b want 0", alarm_hi); end
    samp(8'hC9); samp(8'hCA);
    samp(8'h05);
    checks++; if (alarm_hi !== 1'b0 || alarm_lo !== 1'b0) begin
      errors++; $display("FAIL hi_to_track got %b%b want 00", alarm_hi, alarm_lo); end
    samp(8'h05);
    checks++; if (alarm_lo !== 1'b1) begin errors++; $display("FAIL lo_enter_exit_streak got %b want 1", alarm_lo); end
    samp(8'h10);
    checks++; if (alarm_lo !== 1'b0) begin errors++; $display("FAIL lo_exit got %b want 0", alarm_lo); end
    checks++; if (q_min !== 8'h05 || q_max !== 8'hCA) begin
      errors++; $display("FAIL alarm_minmax got %h/%h want 05/CA", q_min, q_max); end
  endtask

  task automatic test_hi_wins();
    do_clr();
    hi_thr = 8'h10; lo_thr = 8'h80;
    samp(8'h50); samp(8'h50);
    checks++; if (alarm_hi !== 1'b1 || alarm_lo !== 1'b0) begin
      errors++; $display("FAIL hi_wins got %b%b want 10", alarm_hi, alarm_lo); end
    hi_thr = 8'hC8; lo_thr = 8'h10;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_up, exp_dn;
    do_clr();
    for (int i = 0; i < 17; i++) begin
      samp(8'hFF);
      samp(8'h00);
    end
`ifdef COUNT_MONITOR_SAT_EN
    exp_up = 4'hF; exp_dn = 4'hF;
`else
    exp_up = 4'h1; exp_dn = 4'h0;
`endif
    checks++; if (wrap_up_cnt !== exp_up) begin errors++; $display("FAIL wrap17_up got %h want %h", wrap_up_cnt, exp_up); end
    checks++; if (wrap_dn_cnt !== exp_dn) begin errors++; $display("FAIL wrap17_dn got %h want %h", wrap_dn_cnt, exp_dn); end
  endtask

  task automatic test_clr_priority();
    samp(8'h60);
    q_in = 8'hAA; sample = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    sample = 1'b0; clr = 1'b0;
    $display("clr+sample q_in=AA -> min=%h max=%h delta=%h", q_min, q_max, delta);
    checks++; if (q_max !== 8'h00) begin errors++; $display("FAIL clrpri_q_max got %h want 00", q_max); end
    checks++; if (q_min !== 8'hFF) begin errors++; $display("FAIL clrpri_q_min got %h want FF", q_min); end
    checks++; if (delta !== 8'h00 || wrap_up_cnt !== 4'd0 || wrap_dn_cnt !== 4'd0) begin
      errors++; $display("FAIL clrpri_rest got delta=%h up=%0d dn=%0d want 00 0 0", delta, wrap_up_cnt, wrap_dn_cnt); end
    samp(8'h03);
    checks++; if (delta !== 8'h00 || q_min !== 8'h03 || q_max !== 8'h03) begin
      errors++; $display("FAIL post_clr got delta=%h min=%h max=%h want 00 03 03", delta, q_min, q_max); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_minmax();
    test_hold();
    test_wrap();
    test_alarm();
    test_hi_wins();
    test_back_to_back();
    test_clr_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
